// File: rtl/rpm_gate_sequencer.sv
// Counts conditioned blip pulses over a fixed gate window and converts each
// window count to RPM with a serial restoring divider behind a valid/ready port.
module rpm_gate_sequencer #(
    parameter int unsigned GATE_CYCLES   = 50000000,
    parameter int unsigned GATES_PER_SEC = 1,
    parameter int unsigned BLIPS_PER_REV = 80
) (
    input  logic        clk50M,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        blips,
    output logic [15:0] rpm,
    output logic [7:0]  rpm_phone,
    output logic        rpm_valid,
    input  logic        rpm_ready,
    output logic        overrun,
    output logic        busy
);
    localparam int unsigned   GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [31:0]   NUM_SCALE = 32'(60 * GATES_PER_SEC);
    localparam logic [16:0]   DIVISOR   = 17'(BLIPS_PER_REV);

    typedef enum logic [2:0] {S_IDLE, S_GATE, S_LOAD, S_DIV, S_PUBLISH} state_t;
    state_t state, state_nx;

    logic [2:0]    blip_sync;
    logic          blip_edge;
    logic [GW-1:0] gate_cnt;
    logic          window_end;
    logic [15:0]   blip_cnt;
    logic [15:0]   blip_next;
    logic [15:0]   snap;
    logic [31:0]   quo;
    logic [15:0]   rem;
    logic [16:0]   trial;
    logic          trial_ge;
    logic [4:0]    bit_cnt;
    logic [15:0]   rpm_sat;
    logic [7:0]    phone_sat;
    logic          publish;

    // blip_sync[1] is the synchronized level, blip_sync[2] its previous value
    assign blip_edge  = blip_sync[1] & ~blip_sync[2];
    assign window_end = enable && (gate_cnt == GATE_LAST);
    assign blip_next  = (blip_cnt == 16'hFFFF) ? 16'hFFFF : blip_cnt + 16'(blip_edge);
    assign trial      = {rem, quo[31]};
    assign trial_ge   = (trial >= DIVISOR);
    assign rpm_sat    = (|quo[31:16]) ? 16'hFFFF : quo[15:0];
    assign phone_sat  = (|rpm_sat[15:9]) ? 8'hFF : rpm_sat[8:1];

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        publish  = 1'b0;
        if (!enable) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    state_nx = S_GATE;
                S_GATE:    if (window_end) state_nx = S_LOAD;
                S_LOAD:    state_nx = S_DIV;
                S_DIV:     if (bit_cnt == 5'd31) state_nx = S_PUBLISH;
                S_PUBLISH: state_nx = S_GATE;
                default:   state_nx = S_IDLE;
            endcase
            publish = (state == S_PUBLISH);
        end
        busy = (state == S_LOAD) || (state == S_DIV) || (state == S_PUBLISH);
    end

    // Gate and blip counters run in every enabled state so windows abut
    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            blip_sync <= '0;
            gate_cnt  <= '0;
            blip_cnt  <= '0;
            snap      <= '0;
        end else begin
            blip_sync <= {blip_sync[1:0], blips};
            if (!enable) begin
                gate_cnt <= '0;
                blip_cnt <= '0;
            end else if (window_end) begin
                gate_cnt <= '0;
                blip_cnt <= '0;
                snap     <= blip_next;
            end else begin
                gate_cnt <= gate_cnt + 1'b1;
                blip_cnt <= blip_next;
            end
        end
    end

    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            quo     <= '0;
            rem     <= '0;
            bit_cnt <= '0;
        end else if (!enable) begin
            quo     <= '0;
            rem     <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    quo     <= 32'(snap) * NUM_SCALE;
                    rem     <= '0;
                    bit_cnt <= '0;
                end
                S_DIV: begin
                    quo     <= {quo[30:0], trial_ge};
                    rem     <= trial_ge ? 16'(trial - DIVISOR) : trial[15:0];
                    bit_cnt <= bit_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A publish always wins over acceptance; overrun only if the old result was unread
    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            rpm       <= '0;
            rpm_phone <= '0;
            rpm_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (publish) begin
            rpm       <= rpm_sat;
            rpm_phone <= phone_sat;
            rpm_valid <= 1'b1;
            if (rpm_valid && !rpm_ready) overrun <= 1'b1;
        end else if (rpm_valid && rpm_ready) begin
            rpm_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rpm_gate_sequencer.sv
// Self-checking bench for rpm_gate_sequencer: three parameterizations driven
// one at a time, checked every cycle against a window-count reference model.
module tb_rpm_gate_sequencer;
    localparam int G0 = 200;
    localparam int B0 = 80;
    localparam int G1 = 10000;
    localparam int B1 = 1;
    localparam int G2 = 400;
    localparam int B2 = 80;

    logic        clk50M = 1'b0;
    logic        reset_n;
    logic        en    [3];
    logic        bl    [3];
    logic        rdy   [3];
    logic [15:0] rpm_o [3];
    logic [7:0]  ph_o  [3];
    logic        val_o [3];
    logic        ovr_o [3];
    logic        busy_o[3];

    always #5 clk50M = ~clk50M;

    rpm_gate_sequencer #(.GATE_CYCLES(G0), .GATES_PER_SEC(1), .BLIPS_PER_REV(B0)) u_dut0 (
        .clk50M(clk50M), .reset_n(reset_n), .enable(en[0]), .blips(bl[0]),
        .rpm(rpm_o[0]), .rpm_phone(ph_o[0]), .rpm_valid(val_o[0]), .rpm_ready(rdy[0]),
        .overrun(ovr_o[0]), .busy(busy_o[0]));

    rpm_gate_sequencer #(.GATE_CYCLES(G1), .GATES_PER_SEC(1), .BLIPS_PER_REV(B1)) u_dut1 (
        .clk50M(clk50M), .reset_n(reset_n), .enable(en[1]), .blips(bl[1]),
        .rpm(rpm_o[1]), .rpm_phone(ph_o[1]), .rpm_valid(val_o[1]), .rpm_ready(rdy[1]),
        .overrun(ovr_o[1]), .busy(busy_o[1]));

    rpm_gate_sequencer #(.GATE_CYCLES(G2), .GATES_PER_SEC(1), .BLIPS_PER_REV(B2)) u_dut2 (
        .clk50M(clk50M), .reset_n(reset_n), .enable(en[2]), .blips(bl[2]),
        .rpm(rpm_o[2]), .rpm_phone(ph_o[2]), .rpm_valid(val_o[2]), .rpm_ready(rdy[2]),
        .overrun(ovr_o[2]), .busy(busy_o[2]));

    int          n_assert = 0;
    int          n_fail   = 0;
    int          sel      = 0;
    int          cyc      = 0;
    logic        last_en  = 1'b0;
    int          win_cnt [64];
    logic        prev_b  [3];
    logic [15:0] m_rpm   [3];
    logic        m_val   [3];
    logic        m_ovr   [3];

    function automatic int gate_of(input int s);
        case (s)
            0:       return G0;
            1:       return G1;
            default: return G2;
        endcase
    endfunction

    function automatic int bpr_of(input int s);
        case (s)
            0:       return B0;
            1:       return B1;
            default: return B2;
        endcase
    endfunction

    // RPM = floor(blips * 60 / blips_per_rev), count and result clamped to 16 bits
    function automatic logic [15:0] exp_rpm(input int cnt, input int bpr);
        longint c;
        longint q;
        c = (cnt > 65535) ? 65535 : cnt;
        q = (c * 60) / bpr;
        return (q > 65535) ? 16'hFFFF : 16'(q);
    endfunction

    function automatic logic [7:0] exp_phone(input logic [15:0] r);
        int h;
        h = int'(r) / 2;
        return (h > 255) ? 8'hFF : 8'(h);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic compare_all();
        int   g;
        logic eb;
        g  = gate_of(sel);
        eb = last_en && (cyc >= g) && ((cyc % g) <= 33);
        check("busy",      32'(busy_o[sel]), 32'(eb));
        check("rpm",       32'(rpm_o[sel]),  32'(m_rpm[sel]));
        check("rpm_phone", 32'(ph_o[sel]),   32'(exp_phone(m_rpm[sel])));
        check("rpm_valid", 32'(val_o[sel]),  32'(m_val[sel]));
        check("overrun",   32'(ovr_o[sel]),  32'(m_ovr[sel]));
    endtask

    // One clock: drive blips, book any rising edge into the window it lands in,
    // advance the model across the clock edge, then compare on the falling edge.
    task automatic tick(input logic b);
        int g;
        int w;
        g = gate_of(sel);
        bl[sel] = b;
        if (en[sel] && b && !prev_b[sel]) begin
            w = (cyc + 2) / g;
            if (w < 64) win_cnt[w]++;
        end
        prev_b[sel] = b;
        @(posedge clk50M);
        last_en = en[sel];
        if (en[sel]) begin
            cyc++;
            if (cyc >= g && (cyc % g) == 34) begin
                if (m_val[sel] && !rdy[sel]) m_ovr[sel] = 1'b1;
                m_val[sel] = 1'b1;
                m_rpm[sel] = exp_rpm(win_cnt[cyc / g - 1], bpr_of(sel));
            end else if (m_val[sel] && rdy[sel]) begin
                m_val[sel] = 1'b0;
            end
        end else begin
            cyc = 0;
            for (int i = 0; i < 64; i++) win_cnt[i] = 0;
            if (m_val[sel] && rdy[sel]) m_val[sel] = 1'b0;
        end
        @(negedge clk50M);
        compare_all();
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0);
    endtask

    task automatic blips_p4(input int n);
        repeat (n) begin
            tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0);
        end
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 20000) begin
            tick(1'b0);
            guard++;
        end
        check("run_to_bound", 32'(cyc), 32'(target));
    endtask

    task automatic rand_train(input int ncyc);
        int left;
        int h;
        int l;
        left = ncyc;
        while (left > 0) begin
            h = $urandom_range(2, 4);
            l = $urandom_range(2, 5);
            repeat (h) begin rdy[sel] = ($urandom_range(0, 3) == 0); tick(1'b1); end
            repeat (l) begin rdy[sel] = ($urandom_range(0, 3) == 0); tick(1'b0); end
            left -= h + l;
        end
        rdy[sel] = 1'b0;
    endtask

    initial begin
        int next_end;
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b0; bl[i] = 1'b0; rdy[i] = 1'b0; prev_b[i] = 1'b0;
            m_rpm[i] = '0; m_val[i] = 1'b0; m_ovr[i] = 1'b0;
        end
        for (int i = 0; i < 64; i++) win_cnt[i] = 0;
        repeat (3) @(negedge clk50M);
        for (int i = 0; i < 3; i++) begin
            check("reset_rpm",       32'(rpm_o[i]),  32'd0);
            check("reset_rpm_phone", 32'(ph_o[i]),   32'd0);
            check("reset_valid",     32'(val_o[i]),  32'd0);
            check("reset_overrun",   32'(ovr_o[i]),  32'd0);
            check("reset_busy",      32'(busy_o[i]), 32'd0);
        end
        reset_n = 1'b1;
        sel = 0;
        idle(3);

        // Basic: 40 blips in a 200-cycle window
        en[0] = 1'b1;
        blips_p4(40);
        run_to(G0 + 34);
        check("basic_rpm",   32'(rpm_o[0]), 32'd30);
        check("basic_phone", 32'(ph_o[0]),  32'd15);
        check("basic_valid", 32'(val_o[0]), 32'd1);
        rdy[0] = 1'b1; tick(1'b0); rdy[0] = 1'b0;
        check("accept_valid", 32'(val_o[0]), 32'd0);

        // Two unread results in a row
        blips_p4(20);
        run_to(2 * G0 + 34);
        check("hs_first_rpm", 32'(rpm_o[0]), 32'd15);
        blips_p4(40);
        run_to(3 * G0 + 34);
        check("hs_second_rpm", 32'(rpm_o[0]), 32'd30);
        check("hs_valid",      32'(val_o[0]), 32'd1);
        check("hs_overrun",    32'(ovr_o[0]), 32'd1);
        rdy[0] = 1'b1; tick(1'b0); rdy[0] = 1'b0;
        check("hs_accept_valid", 32'(val_o[0]), 32'd0);

        // Window with no blips
        run_to(4 * G0 + 34);
        check("zero_rpm",   32'(rpm_o[0]), 32'd0);
        check("zero_valid", 32'(val_o[0]), 32'd1);

        // Random trains with random ready across several windows
        rand_train(3 * G0);

        // Disable 10 cycles after a window end, mid-divide
        blips_p4(10);
        next_end = (cyc / G0 + 1) * G0;
        run_to(next_end + 10);
        en[0] = 1'b0;
        tick(1'b0);
        check("disable_busy", 32'(busy_o[0]), 32'd0);
        idle(50);
        check("disable_rpm_held", 32'(rpm_o[0]), 32'(m_rpm[0]));

        // Re-enable: fresh window, floor of 22.5
        en[0] = 1'b1;
        blips_p4(30);
        run_to(G0 + 34);
        check("reenable_rpm",   32'(rpm_o[0]), 32'd22);
        check("reenable_phone", 32'(ph_o[0]),  32'd11);
        en[0] = 1'b0;
        idle(3);

        // Saturation: 1200 blips, one blip per revolution
        sel = 1;
        en[1] = 1'b1;
        blips_p4(1200);
        run_to(G1 + 34);
        check("sat_rpm",   32'(rpm_o[1]), 32'd65535);
        check("sat_phone", 32'(ph_o[1]),  32'd255);
        en[1] = 1'b0;
        idle(3);

        // Boundary: 80th edge counted on the window-end cycle
        sel = 2;
        en[2] = 1'b1;
        blips_p4(79);
        run_to(G2 - 3);
        tick(1'b1); tick(1'b1);
        run_to(G2 + 34);
        check("boundary_rpm", 32'(rpm_o[2]), 32'd60);
        blips_p4(21);
        run_to(2 * G2 + 33);
        rdy[2] = 1'b1; tick(1'b0); rdy[2] = 1'b0;
        check("next_window_rpm",    32'(rpm_o[2]), 32'd15);
        check("publish_accept_val", 32'(val_o[2]), 32'd1);
        check("publish_accept_ovr", 32'(ovr_o[2]), 32'd0);
        en[2] = 1'b0;
        idle(3);

        // Asynchronous reset in the middle of a divide
        sel = 0;
        en[0] = 1'b1;
        blips_p4(10);
        run_to(G0 + 10);
        check("pre_reset_busy", 32'(busy_o[0]), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midreset_rpm",     32'(rpm_o[0]),  32'd0);
        check("midreset_phone",   32'(ph_o[0]),   32'd0);
        check("midreset_valid",   32'(val_o[0]),  32'd0);
        check("midreset_overrun", 32'(ovr_o[0]),  32'd0);
        check("midreset_busy",    32'(busy_o[0]), 32'd0);
        en[0] = 1'b0;
        @(negedge clk50M);
        reset_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
